// File: rtl/produce_motion_array.sv
// Multi-channel vertical motion and hammer-collision engine for thrown produce.
// Each channel launches at the bottom, rises to the apex, falls back and retires, or is splatted.
`timescale 1ns/1ps
module produce_motion_array #(
  parameter int N_OBJ      = 4,
  parameter int X_W        = 10,
  parameter int Y_W        = 9,
  parameter int Y_TOP      = 180,
  parameter int Y_BOTTOM   = 480,
  parameter int STEP       = 1,
  parameter int HIT_R      = 16,
  parameter int HIT_FRAMES = 8,
  parameter int SCORE_W    = 16
) (
  input  logic                   clock,
  input  logic                   resetn,
  input  logic                   frame_tick,
  input  logic [N_OBJ-1:0]       launch,
  input  logic [N_OBJ*X_W-1:0]   obj_x,
  input  logic [X_W-1:0]         hammer_x,
  input  logic [Y_W-1:0]         hammer_y,
  input  logic                   hammer_valid,
  output logic [N_OBJ*Y_W-1:0]   obj_y,
  output logic [N_OBJ-1:0]       obj_active,
  output logic [N_OBJ-1:0]       obj_hit,
  output logic [N_OBJ-1:0]       hit_pulse,
  output logic [N_OBJ-1:0]       miss_pulse,
  output logic [SCORE_W-1:0]     score,
  output logic [SCORE_W-1:0]     miss_count
);

  localparam int CNT_W = (HIT_FRAMES < 1) ? 1 : $clog2(HIT_FRAMES + 1);
  localparam int PC_W  = $clog2(N_OBJ + 1);
  localparam int SUM_W = SCORE_W + PC_W;

  localparam logic [Y_W-1:0]   Y_TOP_V  = Y_W'(Y_TOP);
  localparam logic [Y_W-1:0]   Y_BOT_V  = Y_W'(Y_BOTTOM);
  localparam logic [Y_W-1:0]   STEP_V   = Y_W'(STEP);
  localparam logic [Y_W:0]     TOP_LIM  = (Y_W+1)'(Y_TOP + STEP);
  localparam logic [Y_W:0]     STEP_WX  = (Y_W+1)'(STEP);
  localparam logic [Y_W:0]     BOT_WX   = (Y_W+1)'(Y_BOTTOM);
  localparam logic [X_W-1:0]   HIT_RX   = X_W'(HIT_R);
  localparam logic [Y_W-1:0]   HIT_RY   = Y_W'(HIT_R);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(HIT_FRAMES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {IDLE, RISE, FALL, HIT} objState_e;

  objState_e        state    [N_OBJ];
  objState_e        stateNxt [N_OBJ];
  logic [Y_W-1:0]   yPos     [N_OBJ];
  logic [Y_W-1:0]   yNxt     [N_OBJ];
  logic [CNT_W-1:0] hitCnt   [N_OBJ];
  logic [CNT_W-1:0] cntNxt   [N_OBJ];
  logic [N_OBJ-1:0] collide;
  logic [N_OBJ-1:0] hitCond;
  logic [N_OBJ-1:0] missCond;

  function automatic logic [PC_W-1:0] popCount(input logic [N_OBJ-1:0] v);
    logic [PC_W-1:0] c;
    c = '0;
    for (int k = 0; k < N_OBJ; k++) c = c + PC_W'(v[k]);
    return c;
  endfunction

  function automatic logic [SCORE_W-1:0] satAdd(input logic [SCORE_W-1:0] a,
                                                input logic [PC_W-1:0]    b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (s > SUM_W'({SCORE_W{1'b1}})) return '1;
    return s[SCORE_W-1:0];
  endfunction

  // Distances are max-minus-min so the unsigned subtraction never wraps.
  for (genvar g = 0; g < N_OBJ; g++) begin : gChan
    logic [X_W-1:0] ox;
    logic [X_W-1:0] dx;
    logic [Y_W-1:0] dy;
    assign ox         = obj_x[g*X_W +: X_W];
    assign dx         = (hammer_x > ox) ? hammer_x - ox : ox - hammer_x;
    assign dy         = (hammer_y > yPos[g]) ? hammer_y - yPos[g] : yPos[g] - hammer_y;
    assign collide[g] = hammer_valid && (dx < HIT_RX) && (dy < HIT_RY);
    assign obj_y[g*Y_W +: Y_W] = yPos[g];
  end

  always_comb begin
    // NOTE: every next-state signal gets a default first so no latch is inferred.
    hitCond  = '0;
    missCond = '0;
    for (int i = 0; i < N_OBJ; i++) begin
      stateNxt[i] = state[i];
      yNxt[i]     = yPos[i];
      cntNxt[i]   = hitCnt[i];
      unique case (state[i])
        IDLE: begin
          if (launch[i]) begin
            stateNxt[i] = RISE;
            yNxt[i]     = Y_BOT_V;
          end
        end
        RISE: begin
          if (frame_tick) begin
            if (collide[i]) begin
              stateNxt[i] = HIT;
              cntNxt[i]   = CNT_INIT;
              hitCond[i]  = 1'b1;
            end else if ({1'b0, yPos[i]} <= TOP_LIM) begin
              stateNxt[i] = FALL;
              yNxt[i]     = Y_TOP_V;
            end else begin
              yNxt[i] = yPos[i] - STEP_V;
            end
          end
        end
        FALL: begin
          if (frame_tick) begin
            if (collide[i]) begin
              stateNxt[i] = HIT;
              cntNxt[i]   = CNT_INIT;
              hitCond[i]  = 1'b1;
            end else if ({1'b0, yPos[i]} + STEP_WX >= BOT_WX) begin
              stateNxt[i] = IDLE;
              yNxt[i]     = Y_BOT_V;
              missCond[i] = 1'b1;
            end else begin
              yNxt[i] = yPos[i] + STEP_V;
            end
          end
        end
        HIT: begin
          if (frame_tick) begin
            if (hitCnt[i] <= CNT_ONE) begin
              stateNxt[i] = IDLE;
              yNxt[i]     = Y_BOT_V;
              cntNxt[i]   = '0;
            end else begin
              cntNxt[i] = hitCnt[i] - CNT_ONE;
            end
          end
        end
        default: stateNxt[i] = IDLE;
      endcase
    end
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      // NOTE: the per-channel arrays are a handful of flops, so they are reset like any register.
      for (int i = 0; i < N_OBJ; i++) begin
        state[i]  <= IDLE;
        yPos[i]   <= Y_BOT_V;
        hitCnt[i] <= '0;
      end
      obj_active <= '0;
      obj_hit    <= '0;
      hit_pulse  <= '0;
      miss_pulse <= '0;
      score      <= '0;
      miss_count <= '0;
    end else begin
      for (int i = 0; i < N_OBJ; i++) begin
        state[i]      <= stateNxt[i];
        yPos[i]       <= yNxt[i];
        hitCnt[i]     <= cntNxt[i];
        obj_active[i] <= (stateNxt[i] == RISE) || (stateNxt[i] == FALL);
        obj_hit[i]    <= (stateNxt[i] == HIT);
      end
      hit_pulse  <= hitCond;
      miss_pulse <= missCond;
      score      <= satAdd(score, popCount(hitCond));
      miss_count <= satAdd(miss_count, popCount(missCond));
    end
  end

endmodule

// File: tb/tb_produce_motion_array.sv
// Directed scoreboard bench for produce_motion_array: three instances share stimulus
// (STEP=1, STEP=4, and STEP=1 with a 2-bit score) and are checked against queued expectations.
`timescale 1ns/1ps
module tb_produce_motion_array;

  localparam int N  = 4;
  localparam int XW = 10;
  localparam int YW = 9;

  logic            clock = 1'b0;
  logic            resetn = 1'b0;
  logic            frame_tick = 1'b0;
  logic            hammer_valid = 1'b0;
  logic [N-1:0]    launch = '0;
  logic [N*XW-1:0] obj_x = '0;
  logic [XW-1:0]   hammer_x = '0;
  logic [YW-1:0]   hammer_y = '0;

  logic [N*YW-1:0] yM, yF, yS;
  logic [N-1:0]    activeM, hitM, hpM, mpM;
  logic [N-1:0]    activeF, hitF, hpF, mpF;
  logic [N-1:0]    activeS, hitS, hpS, mpS;
  logic [15:0]     scoreM, missM, scoreF, missF;
  logic [1:0]      scoreS, missS;

  produce_motion_array #(.STEP(1)) dutM (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .launch(launch), .obj_x(obj_x),
    .hammer_x(hammer_x), .hammer_y(hammer_y), .hammer_valid(hammer_valid), .obj_y(yM),
    .obj_active(activeM), .obj_hit(hitM), .hit_pulse(hpM), .miss_pulse(mpM),
    .score(scoreM), .miss_count(missM));

  produce_motion_array #(.STEP(4)) dutF (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .launch(launch), .obj_x(obj_x),
    .hammer_x(hammer_x), .hammer_y(hammer_y), .hammer_valid(hammer_valid), .obj_y(yF),
    .obj_active(activeF), .obj_hit(hitF), .hit_pulse(hpF), .miss_pulse(mpF),
    .score(scoreF), .miss_count(missF));

  produce_motion_array #(.STEP(1), .SCORE_W(2)) dutS (
    .clock(clock), .resetn(resetn), .frame_tick(frame_tick), .launch(launch), .obj_x(obj_x),
    .hammer_x(hammer_x), .hammer_y(hammer_y), .hammer_valid(hammer_valid), .obj_y(yS),
    .obj_active(activeS), .obj_hit(hitS), .hit_pulse(hpS), .miss_pulse(mpS),
    .score(scoreS), .miss_count(missS));

  always #5 clock = ~clock;

  typedef struct {
    string       tag;
    logic [63:0] val;
  } exp_t;

  exp_t sbq[$];
  int   vectors = 0;
  int   miscompares = 0;

  task automatic pushExp(input string tag, input logic [63:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sbq.push_back(e);
  endtask

  task automatic check(input logic [63:0] obs);
    exp_t e;
    vectors++;
    if (sbq.size() == 0) begin
      miscompares++;
      $error("FAIL sb_empty observed=%0d expected=<none>", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.val) else begin
        miscompares++;
        $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.val);
      end
    end
  endtask

  function automatic logic [63:0] yv(input logic [N*YW-1:0] v, input int ch);
    return 64'(v[ch*YW +: YW]);
  endfunction

  // Inputs change and outputs are sampled 1ns after each rising edge.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic frame();
    cyc();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  task automatic frames(input int n);
    for (int k = 0; k < n; k++) frame();
  endtask

  task automatic doReset();
    resetn       = 1'b0;
    launch       = '0;
    frame_tick   = 1'b0;
    hammer_valid = 1'b0;
    cyc();
    cyc();
    resetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held with every launch asserted, then released.
    resetn = 1'b0;
    launch = 4'hF;
    cyc();
    cyc();
    pushExp("rst_y", 64'({4{9'd480}}));
    pushExp("rst_active", 64'd0);
    pushExp("rst_hit", 64'd0);
    pushExp("rst_score", 64'd0);
    pushExp("rst_miss", 64'd0);
    check(64'(yM)); check(64'(activeM)); check(64'(hitM)); check(64'(scoreM)); check(64'(missM));
    resetn = 1'b1;
    cyc();
    pushExp("rel_active", 64'hF);
    pushExp("rel_y", 64'({4{9'd480}}));
    check(64'(activeM)); check(64'(yM));
    launch = '0;

    // Full flight on the STEP=4 instance, no hammer.
    doReset();
    launch = 4'b0001;
    cyc();
    launch = '0;
    pushExp("fl_y_tick1", 64'd476);
    frame();
    check(yv(yF, 0));
    frames(73);
    pushExp("fl_y_apex", 64'd180);
    pushExp("fl_active_apex", 64'd1);
    frame();
    check(yv(yF, 0)); check(64'(activeF[0]));
    pushExp("fl_falling", 64'd184);
    frame();
    check(yv(yF, 0));
    pushExp("fl_y_149", 64'd476);
    frames(73);
    check(yv(yF, 0));
    pushExp("fl_miss_pulse", 64'b0001);
    pushExp("fl_y_bottom", 64'd480);
    pushExp("fl_active_end", 64'd0);
    pushExp("fl_miss_count", 64'd1);
    frame();
    check(64'(mpF)); check(yv(yF, 0)); check(64'(activeF)); check(64'(missF));
    pushExp("fl_miss_once", 64'd0);
    cyc();
    check(64'(mpF));
    pushExp("fl_miss_hold", 64'd1);
    frames(2);
    check(64'(missF));

    // Hit during RISE on channel 1: dx=10, dy=5.
    doReset();
    obj_x          = '0;
    obj_x[19:10]   = 10'd300;
    hammer_x       = 10'd310;
    hammer_y       = 9'd470;
    launch         = 4'b0010;
    cyc();
    launch = '0;
    frames(5);
    pushExp("hr_y_pre", 64'd475);
    check(yv(yM, 1));
    hammer_valid = 1'b1;
    pushExp("hr_hit_pulse", 64'b0010);
    pushExp("hr_score", 64'd1);
    pushExp("hr_y_hold", 64'd475);
    pushExp("hr_obj_hit", 64'b0010);
    pushExp("hr_active", 64'd0);
    frame();
    check(64'(hpM)); check(64'(scoreM)); check(yv(yM, 1)); check(64'(hitM)); check(64'(activeM));
    hammer_valid = 1'b0;
    pushExp("hr_pulse_once", 64'd0);
    cyc();
    check(64'(hpM));
    frames(7);
    pushExp("hr_still_hit", 64'b0010);
    pushExp("hr_still_y", 64'd475);
    check(64'(hitM)); check(yv(yM, 1));
    frame();
    pushExp("hr_hit_end", 64'd0);
    pushExp("hr_y_retire", 64'd480);
    pushExp("hr_no_miss", 64'd0);
    pushExp("hr_idle", 64'd0);
    check(64'(hitM)); check(yv(yM, 1)); check(64'(missM)); check(64'(activeM));

    // Simultaneous hits on ch0 and ch2; ch1 far away in X keeps rising.
    doReset();
    obj_x        = {10'd0, 10'd300, 10'd600, 10'd300};
    hammer_x     = 10'd300;
    hammer_y     = 9'd470;
    launch       = 4'b0101;
    cyc();
    launch = '0;
    frame();
    launch = 4'b0010;
    cyc();
    launch = '0;
    frames(9);
    pushExp("mh_score_pre", 64'd0);
    check(64'(scoreM));
    hammer_valid = 1'b1;
    pushExp("mh_score", 64'd2);
    pushExp("mh_pulses", 64'b0101);
    pushExp("mh_ch1_y", 64'd470);
    pushExp("mh_active", 64'b0010);
    frame();
    check(64'(scoreM)); check(64'(hpM)); check(yv(yM, 1)); check(64'(activeM));

    // X window edge: dx=16 misses, dx=15 hits.
    obj_x[19:10] = 10'd316;
    pushExp("edge_dx16_pulse", 64'd0);
    pushExp("edge_dx16_y", 64'd469);
    pushExp("edge_dx16_score", 64'd2);
    frame();
    check(64'(hpM)); check(yv(yM, 1)); check(64'(scoreM));
    obj_x[19:10] = 10'd315;
    pushExp("edge_dx15_pulse", 64'b0010);
    pushExp("edge_dx15_score", 64'd3);
    pushExp("edge_dx15_y", 64'd469);
    frame();
    check(64'(hpM)); check(64'(scoreM)); check(yv(yM, 1));
    hammer_valid = 1'b0;

    // Launch coincident with frame_tick: enter RISE at 480, no step yet.
    doReset();
    launch     = 4'b0001;
    frame_tick = 1'b1;
    cyc();
    launch     = '0;
    frame_tick = 1'b0;
    pushExp("lt_y", 64'd480);
    pushExp("lt_active", 64'b0001);
    check(yv(yM, 0)); check(64'(activeM));
    pushExp("lt_first_step", 64'd479);
    frame();
    check(yv(yM, 0));

    // Launch while ch3 falls is ignored (STEP=4 instance).
    doReset();
    launch = 4'b1000;
    cyc();
    launch = '0;
    frames(76);
    pushExp("lf_y_fall", 64'd184);
    check(yv(yF, 3));
    launch = 4'b1000;
    cyc();
    pushExp("lf_y_ignored", 64'd184);
    pushExp("lf_active", 64'b1000);
    check(yv(yF, 3)); check(64'(activeF));
    pushExp("lf_keeps_falling", 64'd188);
    frame();
    check(yv(yF, 3));
    launch = '0;

    // Saturation: five hits into a 2-bit score.
    doReset();
    obj_x    = {4{10'd300}};
    hammer_x = 10'd300;
    hammer_y = 9'd470;
    launch   = 4'hF;
    cyc();
    launch = '0;
    frames(10);
    hammer_valid = 1'b1;
    pushExp("sat_score4", 64'd3);
    pushExp("sat_wide4", 64'd4);
    pushExp("sat_pulses", 64'hF);
    frame();
    check(64'(scoreS)); check(64'(scoreM)); check(64'(hpS));
    hammer_valid = 1'b0;
    frames(8);
    pushExp("sat_idle_active", 64'd0);
    pushExp("sat_idle_hit", 64'd0);
    check(64'(activeS)); check(64'(hitS));
    launch = 4'b0001;
    cyc();
    launch = '0;
    frames(10);
    hammer_valid = 1'b1;
    pushExp("sat_score5", 64'd3);
    pushExp("sat_wide5", 64'd5);
    pushExp("sat_pulse5", 64'b0001);
    frame();
    check(64'(scoreS)); check(64'(scoreM)); check(64'(hpS));
    hammer_valid = 1'b0;

    // Reset one tick before a channel would retire at the bottom.
    doReset();
    launch = 4'b0100;
    cyc();
    launch = '0;
    frames(149);
    pushExp("rf_y_pre", 64'd476);
    check(yv(yF, 2));
    cyc();
    resetn     = 1'b0;
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
    pushExp("rf_no_pulse", 64'd0);
    pushExp("rf_y", 64'({4{9'd480}}));
    pushExp("rf_active", 64'd0);
    pushExp("rf_miss", 64'd0);
    check(64'(mpF)); check(64'(yF)); check(64'(activeF)); check(64'(missF));
    resetn = 1'b1;
    cyc();
    pushExp("rf_no_late_pulse", 64'd0);
    check(64'(mpF));

    if (sbq.size() != 0) begin
      miscompares++;
      $error("FAIL sb_leftover observed=%0d expected=0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/produce_motion_array.md
Name: produce_motion_array

Overview:
- Multi-channel vertical motion and collision engine for thrown produce objects.
- Each of N_OBJ channels launches from the screen bottom, rises to a top bound, falls back, and retires.
- Positions advance once per frame tick. Each channel is checked against the hammer position every tick.
- Drives the per-object sprite Y coordinates and the score/miss counters consumed by the VGA renderer and HUD.

Parameters:
- N_OBJ, 4, number of independent object channels
- X_W, 10, width of X coordinates
- Y_W, 9, width of Y coordinates
- Y_TOP, 180, apex row; rise stops here
- Y_BOTTOM, 480, launch/retire row
- STEP, 1, pixels moved per frame tick (1..Y_BOTTOM-Y_TOP)
- HIT_R, 16, collision half-window in pixels (strict less-than)
- HIT_FRAMES, 8, frame ticks an object stays in HIT before retiring
- SCORE_W, 16, width of score and miss counters

Ports:
- clock  in  1  system clock
- resetn  in  1  synchronous active-low reset
- frame_tick  in  1  one-cycle pulse per video frame (end of screen)
- launch  in  N_OBJ  per-channel launch request, level-sampled each cycle
- obj_x  in  N_OBJ*X_W  per-channel X position; channel i at bits [i*X_W +: X_W]
- hammer_x  in  X_W  hammer X
- hammer_y  in  Y_W  hammer Y
- hammer_valid  in  1  hammer is swinging; collisions evaluated only when 1
- obj_y  out  N_OBJ*Y_W  per-channel Y, packed as obj_x
- obj_active  out  N_OBJ  channel in RISE or FALL
- obj_hit  out  N_OBJ  channel in HIT (renderer shows splat)
- hit_pulse  out  N_OBJ  one-cycle pulse on the hit transition
- miss_pulse  out  N_OBJ  one-cycle pulse on the retire-at-bottom transition
- score  out  SCORE_W  saturating hit count
- miss_count  out  SCORE_W  saturating miss count

Behaviour:
- **Clock and reset.** Single clock domain. Reset is synchronous and active-low (resetn); the clock port is clock.
- **Reset values.** All channels IDLE; obj_y = Y_BOTTOM for every channel; obj_active, obj_hit, hit_pulse, miss_pulse, score and miss_count all 0.
- **Reset mid-flight.** A reset during flight overrides everything on that edge.
- **Outputs.** All outputs are registered. Effects appear on the clock edge after the triggering input cycle.
- **Per-channel states:** IDLE, RISE, FALL, HIT. Each channel also has a hit counter of width clog2(HIT_FRAMES+1).
- **IDLE:**
  - If launch[i]=1: next state RISE, y = Y_BOTTOM.
  - This happens on any cycle, with or without frame_tick. A launch that coincides with frame_tick causes no motion that cycle.
  - launch[i] is ignored in every other state.
- **Per-tick evaluation.** RISE, FALL and HIT are evaluated only on cycles with frame_tick=1. Otherwise the state holds.
- **Collision (RISE/FALL).** Collision has priority over motion.
  - Condition: hammer_valid=1, |hammer_x - obj_x[i]| < HIT_R and |hammer_y - y| < HIT_R.
  - Differences are computed unsigned-safe, as max minus min.
  - On collision: state HIT, y held, hit counter = HIT_FRAMES, hit_pulse[i]=1 for one cycle.
- **RISE motion.**
  - If y - STEP <= Y_TOP (compare before subtraction; no underflow): y = Y_TOP, state FALL.
  - Else y = y - STEP.
- **FALL motion.**
  - If y + STEP >= Y_BOTTOM (Y_W+1-bit compare): y = Y_BOTTOM, state IDLE, miss_pulse[i]=1 for one cycle.
  - Else y = y + STEP.
- **HIT.**
  - Hit counter decrements each tick.
  - On the tick where the counter is 1: state IDLE, y = Y_BOTTOM.
  - No miss is counted.
- **Status outputs.** obj_active[i] = (RISE or FALL). obj_hit[i] = HIT. Both are registered and consistent with obj_y.
- **Score.**
  - On each cycle, score += popcount(hit_pulse conditions for that cycle), clamped at 2^SCORE_W-1.
  - Several channels hit in the same tick add together.
- **miss_count.** Same rule using the miss conditions.
- **Channel independence.** Channels are fully independent. Any number may be in any state simultaneously.

Test Plan:
1. Reset: hold resetn=0 for 2 cycles with launch=4'hF -> all obj_y=480, obj_active=0, score=0, miss_count=0; on release, all four go RISE the next cycle.
2. Full flight, STEP=4, hammer_valid=0, launch ch0 then 150 frame ticks:
   - obj_y[0] = 476 after the 1st tick.
   - obj_y[0] = 180, FALL after the 75th tick.
   - obj_y[0] = 480, IDLE, miss_pulse[0] once, miss_count=1 after the 150th tick.
3. Hit during RISE, STEP=1, ch1 launched, obj_x[1]=300, hammer at (310,470), valid=1 on the 5th tick:
   - y=475 at that tick: dy=5, dx=10 -> hit_pulse[1] once, score=1, obj_y[1] holds 475.
   - obj_hit[1]=1 for 8 ticks, then IDLE at 480.
4. Simultaneous hits: ch0 and ch2 in flight at identical y/x inside the window on one tick -> score increments by 2 in a single cycle; ch1 out of window keeps moving.
5. Boundary and edge cases:
   - dx=HIT_R exactly -> no hit.
   - Launch asserted while ch3 is in FALL -> ignored.
   - Launch coincident with frame_tick on an IDLE channel -> obj_y=480, RISE, no step that cycle.
6. Saturation: SCORE_W=2, force 5 hits -> score stops at 3. Reset asserted mid-FALL -> channel IDLE at 480, no miss_pulse.
